// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: clears all registers after reset/CLR, then round-robin
// arbitrates NUM_REQ writers. Define RF_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module rf_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clr,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_din,
  input  logic [ADDR_W-1:0]         i_cpu_adrx,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_rf_wr,
  output logic [ADDR_W-1:0]         o_rf_adrx,
  output logic [DATA_W-1:0]         o_rf_din,
  output logic                      o_busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_d;
  logic              w_found;
  logic [PtrW-1:0]   w_winner;
  logic [PtrW-1:0]   w_idx;

`ifdef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = PtrW'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end
`else
  logic [PtrW-1:0] r_rr_ptr, w_rr_ptr_d;

  // Scan starts at r_rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = PtrW'((k + 32'(r_rr_ptr)) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_rr_ptr_d = r_rr_ptr;
    if (!i_rst && r_state == StArb && w_found) begin
      w_rr_ptr_d = (w_winner == PtrW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_d;
    end
  end
`endif

  always_comb begin
    w_state_d   = r_state;
    w_clr_ptr_d = r_clr_ptr;
    o_gnt       = '0;
    o_rf_wr     = 1'b0;
    o_rf_adrx   = i_cpu_adrx;
    o_rf_din    = '0;
    o_busy      = 1'b0;
    // During the reset cycle the outputs already look like the first clear write.
    if (i_rst) begin
      o_busy    = 1'b1;
      o_rf_wr   = 1'b1;
      o_rf_adrx = '0;
    end else begin
      unique case (r_state)
        StClear: begin
          o_busy    = 1'b1;
          o_rf_wr   = 1'b1;
          o_rf_adrx = r_clr_ptr;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            w_state_d   = StArb;
            w_clr_ptr_d = '0;
          end else begin
            w_clr_ptr_d = r_clr_ptr + 1'b1;
          end
        end
        StArb: begin
          if (w_found) begin
            o_gnt[w_winner] = 1'b1;
            o_rf_wr         = 1'b1;
            o_rf_adrx       = i_req_adr[32'(w_winner) * ADDR_W +: ADDR_W];
            o_rf_din        = i_req_din[32'(w_winner) * DATA_W +: DATA_W];
          end
          if (i_clr) begin
            w_state_d   = StClear;
            w_clr_ptr_d = '0;
          end
        end
        default: w_state_d = StClear;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clr_ptr <= w_clr_ptr_d;
    end
  end

endmodule
